// File: rtl/decode_ctrl.sv
// Decode-stage controller: two-entry skid buffer between fetch and execute,
// with immediate extraction, PC-relative target precompute and early JAL redirect.

module imm_selector (
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);
    always_comb begin
        imm_o = '0;
        unique case (instr_i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            7'b0100011:
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            7'b1100011:
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm_o = {instr_i[31:12], 12'b0};
            7'b1101111:
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end
endmodule

module decode_ctrl #(
    parameter int unsigned KILL_SHADOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [31:0] out_target,
    output logic        out_is_branch,
    output logic        out_is_jal,
    output logic        out_is_jalr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    localparam logic [2:0] KILL_INIT = 3'(KILL_SHADOW);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] target;
        logic        br;
        logic        jal;
        logic        jalr;
    } entry_t;

    state_t      state_q;
    entry_t      main_q, skid_q, dec;
    logic [2:0]  kill_q;
    logic        out_valid_q, in_ready_q, redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] imm;
    logic        accept, consume, store;

    imm_selector u_imm (
        .instr_i (in_instr),
        .imm_o   (imm)
    );

    always_comb begin
        dec        = '0;
        dec.instr  = in_instr;
        dec.pc     = in_pc;
        dec.imm    = imm;
        dec.br     = (in_instr[6:0] == 7'b1100011);
        dec.jal    = (in_instr[6:0] == 7'b1101111);
        dec.jalr   = (in_instr[6:0] == 7'b1100111);
        dec.target = (dec.br || dec.jal) ? in_pc + imm : '0;
    end

    assign accept  = in_valid && in_ready_q && !flush;
    assign consume = out_valid_q && out_ready;
    // Instructions in the JAL shadow complete the handshake but are never stored.
    assign store   = accept && (kill_q == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= EMPTY;
            main_q           <= '0;
            skid_q           <= '0;
            kill_q           <= '0;
            out_valid_q      <= 1'b0;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (flush) begin
            state_q          <= EMPTY;
            kill_q           <= '0;
            out_valid_q      <= 1'b0;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
        end else begin
            redirect_valid_q <= store && dec.jal;
            if (store && dec.jal) begin
                redirect_pc_q <= dec.target;
                kill_q        <= KILL_INIT;
            end else if (accept && kill_q != 3'd0) begin
                kill_q <= kill_q - 3'd1;
            end

            case (state_q)
                EMPTY: begin
                    if (store) begin
                        main_q      <= dec;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (store && !consume) begin
                        skid_q     <= dec;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (store) begin
                        main_q <= dec;
                    end else if (consume) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_q     <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_instr      = main_q.instr;
    assign out_pc         = main_q.pc;
    assign out_imm        = main_q.imm;
    assign out_target     = main_q.target;
    assign out_is_branch  = main_q.br;
    assign out_is_jal     = main_q.jal;
    assign out_is_jalr    = main_q.jalr;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
endmodule
